// File: rtl/button_pulser.sv
// ============================================================================
// Module   : button_pulser
// Purpose  : Synchronises and debounces a push-button and turns each press
//            into a one-cycle count request, with optional auto-repeat.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module button_pulser #(
  parameter int STABLE_CYCLES = 4,
  parameter int REPEAT_DELAY  = 16,
  parameter int REPEAT_PERIOD = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_in,
  output logic pulse,
  output logic btn_level
);

  // A delay of 1 would put the first repeat right after the press pulse,
  // so it is stretched to 2 to keep pulses non-adjacent.
  localparam int DELAY_EFF = (REPEAT_DELAY == 1) ? 2 : REPEAT_DELAY;
  localparam int TMR_MAX   = (DELAY_EFF > REPEAT_PERIOD) ? DELAY_EFF : REPEAT_PERIOD;
  localparam int DB_W      = (STABLE_CYCLES > 1) ? $clog2(STABLE_CYCLES) : 1;
  localparam int TMR_W     = (TMR_MAX > 1) ? $clog2(TMR_MAX) : 1;

  localparam logic [DB_W-1:0]  DB_LAST     = DB_W'(STABLE_CYCLES - 1);
  localparam logic [TMR_W-1:0] DELAY_LAST  = TMR_W'((DELAY_EFF > 0) ? DELAY_EFF - 1 : 0);
  localparam logic [TMR_W-1:0] PERIOD_LAST = TMR_W'(REPEAT_PERIOD - 1);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_HOLD   = 2'd1;
  localparam logic [1:0] ST_REPEAT = 2'd2;

  logic             sync1_q;
  logic             btn_s_q;
  logic             deb_q,    deb_d;
  logic [DB_W-1:0]  db_cnt_q, db_cnt_d;
  logic             lvl_q;
  logic [1:0]       state_q,  state_d;
  logic [TMR_W-1:0] tmr_q,    tmr_d;
  logic             pulse_q,  pulse_d;
  logic             w_rise;
  logic             w_fall;

  always_comb begin
    deb_d    = deb_q;
    db_cnt_d = '0;
    if (btn_s_q != deb_q) begin
      if (db_cnt_q == DB_LAST) begin
        deb_d = ~deb_q;
      end else begin
        db_cnt_d = db_cnt_q + 1'b1;
      end
    end
  end

  // Edges of the debounced level against its registered copy; the copy is
  // the visible btn_level, so pulse and btn_level change in the same cycle.
  assign w_rise = deb_q & ~lvl_q;
  assign w_fall = ~deb_q & lvl_q;

  always_comb begin
    state_d = state_q;
    tmr_d   = tmr_q;
    pulse_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        tmr_d = '0;
        if (w_rise) begin
          state_d = ST_HOLD;
          pulse_d = 1'b1;
        end
      end
      ST_HOLD: begin
        if (w_fall) begin
          state_d = ST_IDLE;
          tmr_d   = '0;
        end else if (DELAY_EFF != 0) begin
          if (tmr_q == DELAY_LAST) begin
            state_d = ST_REPEAT;
            tmr_d   = '0;
            pulse_d = 1'b1;
          end else begin
            tmr_d = tmr_q + 1'b1;
          end
        end
      end
      ST_REPEAT: begin
        if (w_fall) begin
          state_d = ST_IDLE;
          tmr_d   = '0;
        end else if (tmr_q == PERIOD_LAST) begin
          tmr_d   = '0;
          pulse_d = 1'b1;
        end else begin
          tmr_d = tmr_q + 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        tmr_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q  <= 1'b0;
      btn_s_q  <= 1'b0;
      deb_q    <= 1'b0;
      db_cnt_q <= '0;
      lvl_q    <= 1'b0;
      state_q  <= ST_IDLE;
      tmr_q    <= '0;
      pulse_q  <= 1'b0;
    end else begin
      sync1_q  <= btn_in;
      btn_s_q  <= sync1_q;
      deb_q    <= deb_d;
      db_cnt_q <= db_cnt_d;
      lvl_q    <= deb_q;
      state_q  <= state_d;
      tmr_q    <= tmr_d;
      pulse_q  <= pulse_d;
    end
  end

  assign pulse     = pulse_q;
  assign btn_level = lvl_q;

endmodule

`default_nettype wire

// File: tb/tb_button_pulser.sv
// ============================================================================
// Module   : tb_button_pulser
// Purpose  : Directed vector table plus press/repeat/reset sequences for
//            button_pulser at default parameters.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_button_pulser;

  logic clk = 1'b0;
  logic rst;
  logic btn_in;
  logic pulse;
  logic btn_level;

  int tests = 0;
  int fails = 0;

  logic [5:0] dcount;

  button_pulser #(
    .STABLE_CYCLES(4),
    .REPEAT_DELAY (16),
    .REPEAT_PERIOD(8)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .btn_in   (btn_in),
    .pulse    (pulse),
    .btn_level(btn_level)
  );

  always #5 clk = ~clk;

  // Downstream 6-bit counter enabled by pulse
  always_ff @(posedge clk) begin
    if (rst) dcount <= '0;
    else if (pulse) dcount <= dcount + 6'd1;
  end

  typedef struct packed {
    logic r;
    logic b;
    logic p;
    logic l;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(input int n, input logic r, input logic b,
                              input logic p, input logic l);
    vec_t v;
    v.r = r; v.b = b; v.p = p; v.l = l;
    for (int i = 0; i < n; i++) vecs.push_back(v);
  endfunction

  task automatic cyc(input logic r, input logic b);
    @(negedge clk);
    rst    = r;
    btn_in = b;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  logic [63:0] pmask;
  logic [63:0] emask;
  int          lvl_cycles;
  int          npulses;
  int          adjacent;
  logic        prev_p;

  initial begin
    rst    = 1'b1;
    btn_in = 1'b0;

    // reset
    add(3, 1, 0, 0, 0);
    // clean press held 12 cycles, then release
    add(6, 0, 1, 0, 0);
    add(1, 0, 1, 1, 1);
    add(5, 0, 1, 0, 1);
    add(6, 0, 0, 0, 1);
    add(4, 0, 0, 0, 0);
    // 3-cycle glitch is rejected
    add(3, 0, 1, 0, 0);
    add(8, 0, 0, 0, 0);
    // bounce 1,0,1,1,0 then steady 1
    add(1, 0, 1, 0, 0);
    add(1, 0, 0, 0, 0);
    add(2, 0, 1, 0, 0);
    add(1, 0, 0, 0, 0);
    add(6, 0, 1, 0, 0);
    add(1, 0, 1, 1, 1);
    add(5, 0, 1, 0, 1);
    add(6, 0, 0, 0, 1);
    add(4, 0, 0, 0, 0);

    for (int i = 0; i < vecs.size(); i++) begin
      cyc(vecs[i].r, vecs[i].b);
      chk($sformatf("vec[%0d].pulse", i), {63'd0, pulse},     {63'd0, vecs[i].p});
      chk($sformatf("vec[%0d].level", i), {63'd0, btn_level}, {63'd0, vecs[i].l});
    end

    // Long hold: press pulse P=6, repeats at P+16/24/32, release lands on P+40
    cyc(1'b1, 1'b0);
    chk("counter_after_reset", {58'd0, dcount}, 64'd0);
    pmask = '0; lvl_cycles = 0; npulses = 0; adjacent = 0; prev_p = 1'b0;
    for (int c = 0; c < 60; c++) begin
      cyc(1'b0, (c < 40) ? 1'b1 : 1'b0);
      if (pulse) begin
        pmask[c] = 1'b1;
        npulses++;
      end
      if (pulse && prev_p) adjacent++;
      prev_p = pulse;
      if (btn_level) lvl_cycles++;
    end
    emask = '0;
    emask[6] = 1'b1; emask[22] = 1'b1; emask[30] = 1'b1; emask[38] = 1'b1;
    chk("hold_pulse_positions", pmask, emask);
    chk("hold_pulse_count", 64'(npulses), 64'd4);
    chk("hold_level_cycles", 64'(lvl_cycles), 64'd40);
    chk("hold_no_adjacent", 64'(adjacent), 64'd0);
    chk("hold_counter", {58'd0, dcount}, 64'd4);

    // Reset mid-hold at P+10 with the button still held
    pmask = '0;
    for (int c = 0; c < 30; c++) begin
      cyc((c == 16) ? 1'b1 : 1'b0, 1'b1);
      if (pulse) pmask[c] = 1'b1;
      if (c == 16) begin
        chk("rst_pulse", {63'd0, pulse}, 64'd0);
        chk("rst_level", {63'd0, btn_level}, 64'd0);
        chk("rst_counter", {58'd0, dcount}, 64'd0);
      end
    end
    emask = '0;
    emask[6] = 1'b1; emask[23] = 1'b1;
    chk("rst_pulse_positions", pmask, emask);
    chk("rst_level_after", {63'd0, btn_level}, 64'd1);
    chk("rst_counter_after", {58'd0, dcount}, 64'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/button_pulser.md
BUTTON_PULSER -- requirements
Module: button_pulser

Interface
REQ-001 Parameter STABLE_CYCLES, default 4: consecutive synchronized cycles of a changed input needed to accept a new level; legal range 1..255.
REQ-002 Parameter REPEAT_DELAY, default 16: cycles from the press pulse to the first auto-repeat pulse; 0 disables auto-repeat; legal range 0..1023.
REQ-003 Parameter REPEAT_PERIOD, default 8: cycles between successive auto-repeat pulses; legal range 2..1023.
REQ-004 clk  input  1  system clock; all state updates on its rising edge.
REQ-005 rst  input  1  reset, synchronous, active-high.
REQ-006 btn_in  input  1  raw push-button, asynchronous to clk, may bounce.
REQ-007 pulse  output  1  registered one-cycle count request; drives the enb input of the downstream 6-bit counter.
REQ-008 btn_level  output  1  registered debounced button level.

Function
REQ-009 btn_in SHALL pass through a 2-flop synchronizer; only the second-flop output (btn_s) SHALL be used by the downstream logic.
REQ-010 A debounce counter SHALL increment on each edge where btn_s != btn_level.
REQ-011 The debounce counter SHALL clear on any edge where btn_s == btn_level.
REQ-012 On the edge where the debounce counter equals STABLE_CYCLES-1 and btn_s != btn_level, btn_level SHALL toggle and the counter SHALL clear.
REQ-013 Press latency SHALL be exactly STABLE_CYCLES+2 clocks: btn_in first sampled high at edge k gives btn_level=1 and pulse=1 after edge k+STABLE_CYCLES+2.
REQ-014 Release latency SHALL also be STABLE_CYCLES+2 clocks.
REQ-015 A release SHALL never generate a pulse.
REQ-016 The FSM SHALL have three states: IDLE (btn_level=0), HOLD (pressed, waiting REPEAT_DELAY) and REPEAT (pressed, emitting every REPEAT_PERIOD).
REQ-017 IDLE->HOLD SHALL occur on the btn_level 0->1 edge, with pulse=1 for exactly that one cycle.
REQ-018 HOLD->REPEAT SHALL occur REPEAT_DELAY cycles after the press pulse if btn_level is still 1, with one pulse cycle; with REPEAT_DELAY=0, HOLD SHALL be held until release.
REQ-019 In REPEAT, one pulse cycle SHALL be issued every REPEAT_PERIOD cycles while btn_level=1.
REQ-020 HOLD or REPEAT SHALL go to IDLE on the btn_level 1->0 edge; the repeat timer SHALL clear.
REQ-021 If release coincides with a scheduled repeat edge, release SHALL win and no pulse SHALL be issued.
REQ-022 pulse SHALL never be high in two consecutive cycles.
REQ-023 An input pulse or bounce shorter than STABLE_CYCLES synchronized cycles SHALL leave btn_level and pulse unchanged.
REQ-024 Counter widths SHALL be sized from the parameters (clog2 of each parameter), and counters SHALL saturate or clear, never wrap.

Reset
REQ-025 While rst=1, the synchronizer flops, debounce counter, repeat timer, btn_level and pulse SHALL all be 0, with the FSM in IDLE, after the next clk edge.
REQ-026 rst SHALL override all other activity, including mid-debounce and mid-repeat; no pulse SHALL be emitted in the cycle after an edge with rst=1.
REQ-027 If btn_in is held high through reset, it SHALL be treated as a new press: pulse occurs STABLE_CYCLES+2 clocks after the first edge with rst=0.

Verification (defaults STABLE_CYCLES=4, REPEAT_DELAY=16, REPEAT_PERIOD=8)
REQ-028 rst=1 for 3 cycles with btn_in=0 -> pulse=0, btn_level=0 throughout; the downstream counter stays at 0.
REQ-029 Clean press held 12 cycles, then released -> exactly one pulse, 6 clocks after the first high sample; btn_level rises and falls with 6-clock latency each.
REQ-030 btn_in pattern 1,0,1,1,0,1 then steady 1 -> exactly one pulse, 6 clocks after steady-1 begins.
REQ-031 btn_in high for 3 cycles only -> no pulse, btn_level stays 0.
REQ-032 btn_level held high 40 cycles (press pulse at edge P) -> pulses at P, P+16, P+24, P+32, then none; the downstream counter reads 4.
REQ-033 rst pulsed at P+10 while the button stays held -> pulse=0 and btn_level=0 after the reset edge; a new pulse 6 clocks after rst deasserts.
